regfile_wb_arbiter: RTL
=======================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DW, default 32: write-data width, matches register file BusW.
REQ-002 Parameter STARVE_MAX, default 3: consecutive lost cycles after which requester B gets forced priority; legal range 1..15.
REQ-003 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-004 Rst_n  input  1  asynchronous, active-low reset; assertion clears state immediately, deassertion is sampled on posedge Clk.
REQ-005 Stall  input  1  when high, nothing is accepted this cycle.
REQ-006 AValid  input  1  requester A (ALU writeback) has a write pending.
REQ-007 ARW  input  5  destination register for A.
REQ-008 AData  input  DW  write data for A.
REQ-009 AReady  output  1  A transfer occurs in a cycle where AValid and AReady are both high.
REQ-010 BValid, BRW[4:0], BData[DW-1:0]  input  requester B (multi-cycle unit writeback), same meaning as the A signals.
REQ-011 BReady  output  1  B transfer occurs in a cycle where BValid and BReady are both high.
REQ-012 RegWr  output  1  registered write enable to the register file.
REQ-013 RW  output  5  registered write address to the register file.
REQ-014 BusW  output  DW  registered write data to the register file.
REQ-015 BForced  output  1  registered pulse, high for one cycle after a B grant won by starvation override.

Function
REQ-016 Default priority: A wins when both requesters are valid.
REQ-017 At most one of AReady or BReady is high in any cycle.
REQ-018 AReady and BReady are combinational from the current Valids, Stall and the starvation counter.
REQ-019 AReady = AValid & ~Stall & ~(BValid & starve_cnt==STARVE_MAX).
REQ-020 BReady = BValid & ~Stall & (~AValid | starve_cnt==STARVE_MAX).
REQ-021 Requesters hold Valid, RW and Data stable until the transfer occurs; the block does not capture unaccepted requests.
REQ-022 Latency: a transfer in cycle N drives RegWr, RW and BusW with the granted request for cycle N+1, so the register file writes on the negedge inside N+1.
REQ-023 Cycle with no transfer: next RegWr = 0; RW and BusW hold their previous values.
REQ-024 Transfer with destination register 0: the handshake completes, but next RegWr = 0 (register 0 is never written); RW and BusW update.
REQ-025 starve_cnt is 4 bits wide.
REQ-026 starve_cnt increments by 1 each cycle that BValid=1, Stall=0 and A transfers; it saturates at STARVE_MAX.
REQ-027 starve_cnt clears to 0 on a B transfer or in any cycle with BValid=0.
REQ-028 starve_cnt holds while Stall=1 and BValid=1.
REQ-029 Override: when starve_cnt==STARVE_MAX and BValid=1, B wins even if AValid=1; next BForced = 1.
REQ-030 BForced = 0 in all other cycles.
REQ-031 Same destination from A and B: the writes are serialised in grant order; the last granted request determines the final register value.
REQ-032 Throughput: one write per cycle; back-to-back transfers produce RegWr high on consecutive cycles.

Reset
REQ-033 While Rst_n=0: RegWr=0, RW=0, BusW=0, BForced=0, starve_cnt=0, and AReady=BReady=0 regardless of inputs.
REQ-034 Reset asserted mid-operation discards the in-flight output-register write; RegWr drops to 0 asynchronously.
REQ-035 First possible transfer is in the first cycle after Rst_n deassertion is sampled.

Verification
REQ-036 A only: AValid=1, ARW=5, AData=0xDEADBEEF in cycle N -> AReady=1 in N; RegWr=1, RW=5, BusW=0xDEADBEEF in N+1; RegWr=0 in N+2 if AValid drops.
REQ-037 Starvation, STARVE_MAX=3: A and B valid continuously -> A granted 3 cycles; B granted in the 4th with BForced=1 the following cycle; A granted again after that.
REQ-038 Register 0: BValid=1, BRW=0, BData=0x1234 -> BReady=1; RegWr stays 0 the next cycle; RW=0, BusW=0x1234.
REQ-039 Stall: both requesters valid with Stall=1 for 2 cycles -> both Ready signals 0, RegWr=0, starve_cnt unchanged; normal arbitration resumes when Stall drops.
REQ-040 Async reset: assert Rst_n=0 mid-cycle while RegWr=1 -> RegWr, RW, BusW and BForced go to 0 without a clock edge; the first transfer occurs in the first cycle after release.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter feeding a register-file write port.
// Handshake: a transfer happens in a cycle where Valid and Ready are both
// high at the rising Clk edge. A requester holds Valid, RW and Data stable
// until then. Ready is combinational and never depends on this cycle's RW
// or Data. At most one Ready is high per cycle. A has default priority.
// B is forced through after STARVE_MAX consecutive lost cycles.
// The granted request appears on RegWr/RW/BusW one cycle after the transfer.
module regfile_wb_arbiter #(
  parameter int DW         = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          Stall,
  input  logic          AValid,
  input  logic [4:0]    ARW,
  input  logic [DW-1:0] AData,
  output logic          AReady,
  input  logic          BValid,
  input  logic [4:0]    BRW,
  input  logic [DW-1:0] BData,
  output logic          BReady,
  output logic          RegWr,
  output logic [4:0]    RW,
  output logic [DW-1:0] BusW,
  output logic          BForced
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  // active_q stays low until the first rising edge that sees Rst_n high.
  // Grants are therefore first possible in the cycle after that edge,
  // even if reset is released part-way through a cycle.
  logic          active_q,  active_d;
  logic [3:0]    starve_q,  starve_d;
  logic          reg_wr_q,  reg_wr_d;
  logic [4:0]    rw_q,      rw_d;
  logic [DW-1:0] bus_w_q,   bus_w_d;
  logic          forced_q,  forced_d;

  logic force_b;
  logic a_xfer;
  logic b_xfer;

  // Arbitration: starvation override, Ready generation and transfer detect
  always_comb begin
    force_b = BValid && (starve_q == STARVE_LIM);
    AReady  = active_q && AValid && !Stall && !force_b;
    BReady  = active_q && BValid && !Stall && (!AValid || force_b);
    a_xfer  = AValid && AReady;
    b_xfer  = BValid && BReady;
  end

  // Next-state: starvation counter and output write registers
  always_comb begin
    active_d = 1'b1;
    starve_d = starve_q;
    reg_wr_d = 1'b0;
    rw_d     = rw_q;
    bus_w_d  = bus_w_q;
    forced_d = 1'b0;

    // A pending B that loses to A while not stalled is one step closer to
    // being forced. An absent B or a B transfer restarts the count.
    if (!BValid) begin
      starve_d = 4'd0;
    end else if (Stall) begin
      starve_d = starve_q;
    end else if (b_xfer) begin
      starve_d = 4'd0;
    end else if (a_xfer && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 4'd1;
    end

    // Register 0 is hard-wired: its address and data still update, but
    // the write enable stays low.
    if (a_xfer) begin
      rw_d     = ARW;
      bus_w_d  = AData;
      reg_wr_d = (ARW != 5'd0);
    end else if (b_xfer) begin
      rw_d     = BRW;
      bus_w_d  = BData;
      reg_wr_d = (BRW != 5'd0);
      forced_d = force_b;
    end
  end

  // State register with asynchronous active-low clear
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      active_q <= 1'b0;
      starve_q <= 4'd0;
      reg_wr_q <= 1'b0;
      rw_q     <= 5'd0;
      bus_w_q  <= '0;
      forced_q <= 1'b0;
    end else begin
      active_q <= active_d;
      starve_q <= starve_d;
      reg_wr_q <= reg_wr_d;
      rw_q     <= rw_d;
      bus_w_q  <= bus_w_d;
      forced_q <= forced_d;
    end
  end

  // Register-file write port outputs
  always_comb begin
    RegWr   = reg_wr_q;
    RW      = rw_q;
    BusW    = bus_w_q;
    BForced = forced_q;
  end

endmodule
